biriscv_icache_arb: RTL

- Shares the single instruction-cache port between two requesters:
  - the frontend fetch unit (requester F, primary);
  - a secondary instruction-side requester (requester P, e.g. prefetcher or debug fetch).
- Tracks ownership of outstanding reads in an order FIFO and routes each in-order response back to its issuer.
- Sequences cache flush/invalidate so that maintenance is issued only once all outstanding reads have drained.
- Sits between biriscv_fetch (plus the secondary requester) and the icache.

---
 rtl/biriscv_icache_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/biriscv_icache_arb.sv
// Shares the instruction-cache port between the fetch unit (F) and a secondary requester (P),
// routes in-order responses back via an owner FIFO, and sequences flush/invalidate after drain.
module biriscv_icache_arb #(
    parameter int unsigned MAX_OUTSTANDING   = 2,
    parameter int unsigned MAX_OUTSTANDING_W = 1,
    parameter int unsigned STARVE_LIMIT      = 8,
    parameter int unsigned STARVE_W          = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        f_rd_i,
    input  logic [31:0] f_pc_i,
    input  logic [1:0]  f_priv_i,
    input  logic        f_flush_i,
    input  logic        f_invalidate_i,
    output logic        f_accept_o,
    output logic        f_maint_ack_o,
    output logic        f_valid_o,
    input  logic        p_rd_i,
    input  logic [31:0] p_pc_i,
    input  logic [1:0]  p_priv_i,
    output logic        p_accept_o,
    output logic        p_valid_o,
    output logic [63:0] rsp_inst_o,
    output logic        rsp_error_o,
    output logic        rsp_page_fault_o,
    output logic        ic_rd_o,
    output logic [31:0] ic_pc_o,
    output logic [1:0]  ic_priv_o,
    output logic        ic_flush_o,
    output logic        ic_invalidate_o,
    input  logic        ic_accept_i,
    input  logic        ic_valid_i,
    input  logic        ic_error_i,
    input  logic [63:0] ic_inst_i,
    input  logic        ic_page_fault_i,
    output logic        proto_err_o
);
    localparam int unsigned PtrW = (MAX_OUTSTANDING_W > 0) ? MAX_OUTSTANDING_W : 1;
    localparam int unsigned CntW = MAX_OUTSTANDING_W + 1;
    localparam logic [PtrW-1:0]     PtrLast   = PtrW'(MAX_OUTSTANDING - 1);
    localparam logic [CntW-1:0]     CntFull   = CntW'(MAX_OUTSTANDING);
    localparam logic [STARVE_W-1:0] StarveMax = STARVE_W'(STARVE_LIMIT);
    localparam logic IdF = 1'b0;
    localparam logic IdP = 1'b1;

    typedef enum logic [1:0] {StIdle, StDrain, StMaint} state_e;

    state_e                     state_q, state_d;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PtrW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]            count_q;
    logic [STARVE_W-1:0]        starve_q;
    logic                       lock_q, lock_id_q, proto_err_q;

    logic grant_valid, grant_id, fifo_full, fifo_empty, push, pop, head_id;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = IdF;
        if (lock_q) begin
            grant_valid = 1'b1;
            grant_id    = lock_id_q;
        end else if (starve_q == StarveMax && p_rd_i) begin
            grant_valid = 1'b1;
            grant_id    = IdP;
        end else if (f_rd_i) begin
            grant_valid = 1'b1;
            grant_id    = IdF;
        end else if (p_rd_i) begin
            grant_valid = 1'b1;
            grant_id    = IdP;
        end
    end

    assign fifo_full  = (count_q == CntFull);
    assign fifo_empty = (count_q == '0);

    assign ic_rd_o   = grant_valid & ~fifo_full & (state_q == StIdle);
    assign ic_pc_o   = !ic_rd_o ? '0 : (grant_id == IdP) ? p_pc_i : f_pc_i;
    assign ic_priv_o = !ic_rd_o ? '0 : (grant_id == IdP) ? p_priv_i : f_priv_i;

    assign push       = ic_rd_o & ic_accept_i;
    assign f_accept_o = push & (grant_id == IdF);
    assign p_accept_o = push & (grant_id == IdP);

    assign head_id   = owner_q[rd_ptr_q];
    assign pop       = ic_valid_i & ~fifo_empty;
    assign f_valid_o = pop & (head_id == IdF);
    assign p_valid_o = pop & (head_id == IdP);

    assign rsp_inst_o       = ic_inst_i;
    assign rsp_error_o      = ic_error_i;
    assign rsp_page_fault_o = ic_page_fault_i;
    assign proto_err_o      = proto_err_q;

    always_comb begin
        state_d         = state_q;
        ic_flush_o      = 1'b0;
        ic_invalidate_o = 1'b0;
        f_maint_ack_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // A read presented but not yet accepted must finish before draining.
                if ((f_flush_i || f_invalidate_i) && !(ic_rd_o && !ic_accept_i)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (count_q == '0) state_d = StMaint;
            end
            StMaint: begin
                ic_flush_o      = f_flush_i;
                ic_invalidate_o = f_invalidate_i;
                f_maint_ack_o   = 1'b1;
                state_d         = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            lock_q      <= 1'b0;
            lock_id_q   <= IdF;
            proto_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) begin
                owner_q[wr_ptr_q] <= grant_id;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
            if (ic_rd_o && !ic_accept_i) begin
                lock_q    <= 1'b1;
                lock_id_q <= grant_id;
            end else if (push) begin
                lock_q <= 1'b0;
            end
            if (!p_rd_i || p_accept_o) begin
                starve_q <= '0;
            end else if (starve_q != StarveMax) begin
                starve_q <= starve_q + 1'b1;
            end
            if (ic_valid_i && fifo_empty) proto_err_q <= 1'b1;
        end
    end
endmodule
